// File: rtl/cpu_req_gen_if.sv
// I-cache request port: the generator drives read_en/request_addr, the cache answers with hit/data.
interface cpu_req_gen_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              read_en;
  logic [ADDR_W-1:0] request_addr;
  logic              hit;
  logic [DATA_W-1:0] requested_data;

  modport master (output read_en, request_addr, input hit, requested_data);
  modport slave  (input read_en, request_addr, output hit, requested_data);
endinterface

// File: rtl/cpu_req_gen.sv
// CPU fetch-request generator/checker: issues NUM_REQ reads in a selectable
// address pattern, holds each until hit, checks returned data against
// addr ^ DATA_KEY and keeps request/error/stall statistics.
module cpu_req_gen #(
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       NUM_REQ   = 64,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int unsigned       STRIDE    = 4,
  parameter int unsigned       LOOP_LEN  = 8,
  parameter int unsigned       GAP       = 0,
  parameter int unsigned       TIMEOUT   = 1024,
  parameter logic [DATA_W-1:0] DATA_KEY  = DATA_W'(32'hA5A5_A5A5)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        mode,
  cpu_req_gen_if.master     cache,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic [15:0]       req_cnt,
  output logic [15:0]       err_cnt,
  output logic [31:0]       stall_cnt,
  output logic [ADDR_W-1:0] first_err_addr
);
  typedef enum logic [2:0] {S_IDLE, S_REQ, S_GAP, S_DONE, S_TOUT} state_e;

  // Galois taps for x^32+x^22+x^2+x+1, right-shifting form
  localparam logic [31:0]       LFSR_TAPS = 32'h8020_0003;
  localparam logic [31:0]       T_LAST    = 32'(TIMEOUT - 1);
  localparam logic [31:0]       G_LAST    = (GAP == 0) ? 32'd0 : 32'(GAP - 1);
  localparam logic [31:0]       L_LAST    = 32'(LOOP_LEN - 1);
  localparam logic [15:0]       N_REQ     = 16'(NUM_REQ);
  localparam logic [ADDR_W-1:0] ALIGN     = ~ADDR_W'(3);
  // Seed 1 masks to 0, so every mode starts at the aligned base
  localparam logic [ADDR_W-1:0] ADDR0     = BASE_ADDR & ALIGN;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d, addr_nxt, ferr_q, ferr_d;
  logic [31:0]       lfsr_q, lfsr_d, lfsr_nxt;
  logic [31:0]       idx_q, idx_d, idx_nxt;
  logic [31:0]       wait_q, wait_d, gap_q, gap_d, stall_q, stall_d;
  logic [15:0]       req_q, req_d, err_q, err_d;
  logic [1:0]        mode_q, mode_d;
  logic              go, accept, last, mismatch;

  assign go       = start && (state_q == S_IDLE || state_q == S_DONE || state_q == S_TOUT);
  assign accept   = (state_q == S_REQ) && cache.hit;
  assign last     = (req_q + 16'd1) == N_REQ;
  assign mismatch = cache.requested_data != (DATA_W'(addr_q) ^ DATA_KEY);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Next-state: start only honoured when not busy; hit wins over timeout
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE, S_TOUT: if (start) state_d = S_REQ;
      S_REQ: begin
        if (cache.hit)               state_d = last ? S_DONE : ((GAP == 0) ? S_REQ : S_GAP);
        else if (wait_q == T_LAST)   state_d = S_TOUT;
      end
      S_GAP:   if (gap_q == G_LAST) state_d = S_REQ;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from state; address and counters come straight from flops
  always_comb begin
    cache.read_en      = (state_q == S_REQ);
    cache.request_addr = addr_q;
    busy               = (state_q == S_REQ) || (state_q == S_GAP);
    done               = (state_q == S_DONE);
    timeout            = (state_q == S_TOUT);
    req_cnt            = req_q;
    err_cnt            = err_q;
    stall_cnt          = stall_q;
    first_err_addr     = ferr_q;
  end

  // Next-address generation and statistics update
  always_comb begin
    lfsr_nxt = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 32'd0);
    idx_nxt  = (idx_q == L_LAST) ? 32'd0 : idx_q + 32'd1;
    case (mode_q)
      2'd0:    addr_nxt = addr_q + ADDR_W'(4);
      2'd1:    addr_nxt = addr_q + ADDR_W'(STRIDE);
      2'd2:    addr_nxt = BASE_ADDR + ADDR_W'(lfsr_nxt);
      default: addr_nxt = BASE_ADDR + ADDR_W'({idx_nxt, 2'b00});
    endcase
    addr_nxt = addr_nxt & ALIGN;

    addr_d  = addr_q;
    lfsr_d  = lfsr_q;
    idx_d   = idx_q;
    mode_d  = mode_q;
    req_d   = req_q;
    err_d   = err_q;
    stall_d = stall_q;
    ferr_d  = ferr_q;
    wait_d  = (state_q == S_REQ && !cache.hit) ? wait_q + 32'd1 : 32'd0;
    gap_d   = (state_q == S_GAP) ? gap_q + 32'd1 : 32'd0;

    if (go) begin
      addr_d  = ADDR0;
      lfsr_d  = 32'h1;
      idx_d   = '0;
      mode_d  = mode;
      req_d   = '0;
      err_d   = '0;
      stall_d = '0;
      ferr_d  = '0;
    end else if (state_q == S_REQ) begin
      if (!cache.hit) begin
        if (stall_q != '1) stall_d = stall_q + 32'd1;
      end else begin
        req_d = req_q + 16'd1;
        if (mismatch) begin
          if (err_q != 16'hFFFF) err_d  = err_q + 16'd1;
          if (err_q == 16'd0)    ferr_d = addr_q;
        end
        if (!accept || !last) begin
          addr_d = addr_nxt;
          lfsr_d = lfsr_nxt;
          idx_d  = idx_nxt;
        end
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q  <= '0;
      lfsr_q  <= 32'h1;
      idx_q   <= '0;
      mode_q  <= '0;
      req_q   <= '0;
      err_q   <= '0;
      stall_q <= '0;
      ferr_q  <= '0;
      wait_q  <= '0;
      gap_q   <= '0;
    end else begin
      addr_q  <= addr_d;
      lfsr_q  <= lfsr_d;
      idx_q   <= idx_d;
      mode_q  <= mode_d;
      req_q   <= req_d;
      err_q   <= err_d;
      stall_q <= stall_d;
      ferr_q  <= ferr_d;
      wait_q  <= wait_d;
      gap_q   <= gap_d;
    end
  end
endmodule

// File: tb/tb_cpu_req_gen.sv
// Bench for cpu_req_gen: two instances (GAP=0 and GAP=2), a cache responder
// with random latency and selectable corruption, and an address model built
// from the pattern formulas.
module tb_cpu_req_gen;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam logic [31:0] KEY = 32'hA5A5_A5A5;

  logic clk = 1'b0, rst = 1'b0, start = 1'b0, sel = 1'b0, hit = 1'b0;
  logic [1:0]    mode = 2'd0;
  logic [DW-1:0] rdata = '0;
  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  cpu_req_gen_if #(.ADDR_W(AW), .DATA_W(DW)) if_a ();
  cpu_req_gen_if #(.ADDR_W(AW), .DATA_W(DW)) if_b ();
  assign if_a.hit = hit;
  assign if_a.requested_data = rdata;
  assign if_b.hit = hit;
  assign if_b.requested_data = rdata;

  logic start_a, start_b;
  assign start_a = start & ~sel;
  assign start_b = start & sel;

  logic busy_a, done_a, tmo_a, busy_b, done_b, tmo_b;
  logic [15:0] rc_a, ec_a, rc_b, ec_b;
  logic [31:0] sc_a, sc_b;
  logic [AW-1:0] fe_a, fe_b;

  cpu_req_gen #(.ADDR_W(AW), .DATA_W(DW), .NUM_REQ(4), .BASE_ADDR(32'h1000), .STRIDE(16),
                .LOOP_LEN(2), .GAP(0), .TIMEOUT(16)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .mode(mode), .cache(if_a),
    .busy(busy_a), .done(done_a), .timeout(tmo_a), .req_cnt(rc_a), .err_cnt(ec_a),
    .stall_cnt(sc_a), .first_err_addr(fe_a));

  cpu_req_gen #(.ADDR_W(AW), .DATA_W(DW), .NUM_REQ(5), .BASE_ADDR(32'h0), .STRIDE(16),
                .LOOP_LEN(2), .GAP(2), .TIMEOUT(16)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .mode(mode), .cache(if_b),
    .busy(busy_b), .done(done_b), .timeout(tmo_b), .req_cnt(rc_b), .err_cnt(ec_b),
    .stall_cnt(sc_b), .first_err_addr(fe_b));

  // View of whichever instance is currently selected
  logic re, busy, done, tmo;
  logic [AW-1:0] addr, ferr;
  logic [15:0] rcnt, ecnt;
  logic [31:0] scnt;
  assign re   = sel ? if_b.read_en : if_a.read_en;
  assign addr = sel ? if_b.request_addr : if_a.request_addr;
  assign busy = sel ? busy_b : busy_a;
  assign done = sel ? done_b : done_a;
  assign tmo  = sel ? tmo_b : tmo_a;
  assign rcnt = sel ? rc_b : rc_a;
  assign ecnt = sel ? ec_b : ec_a;
  assign scnt = sel ? sc_b : sc_a;
  assign ferr = sel ? fe_b : fe_a;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] lfsr_adv(input logic [31:0] v);
    return {1'b0, v[31:1]} ^ (v[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  // Address n of a run, straight from the pattern formulas
  function automatic logic [31:0] model_addr(input logic [1:0] m, input int n, input logic [31:0] base);
    logic [31:0] l;
    l = 32'h1;
    case (m)
      2'd0: return base + 32'(4 * n);
      2'd1: return base + 32'(16 * n);
      2'd2: begin
        for (int i = 0; i < n; i++) l = lfsr_adv(l);
        return base + {l[31:2], 2'b00};
      end
      default: return base + 32'(4 * (n % 2));
    endcase
  endfunction

  // One complete run: lat_fix<0 means random latency 0..4; bad_idx = request to corrupt
  task automatic run(input logic s, input logic [1:0] m, input int lat_fix, input int bad_idx);
    int num, gap, n, wait_c, gap_c, lat, exp_stall, exp_err;
    logic [31:0] base, exp_first, ea;
    logic seen_done;
    sel = s;
    num = s ? 5 : 4;
    gap = s ? 2 : 0;
    base = s ? 32'h0 : 32'h1000;
    hit = 1'b0;
    @(negedge clk); start = 1'b1; mode = m;
    @(negedge clk); start = 1'b0;
    chk("start_clears", {done, tmo, rcnt, ecnt, scnt}, 64'h0);
    n = 0; wait_c = 0; gap_c = 0; exp_stall = 0; exp_err = 0; exp_first = 0; seen_done = 1'b0;
    lat = (lat_fix >= 0) ? lat_fix : int'($urandom_range(0, 4));
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (done) begin seen_done = 1'b1; break; end
      if (re) begin
        ea = model_addr(m, n, base);
        chk("addr", addr, ea);
        if (wait_c == 0 && n > 0) chk("gap_len", gap_c, gap);
        gap_c = 0;
        if (n == 1 && wait_c == 0) begin start = 1'b1; mode = m + 2'd1; end
        if (wait_c < lat) begin
          hit = 1'b0; wait_c++; exp_stall++;
        end else begin
          hit = 1'b1;
          rdata = ea ^ KEY;
          if (n == bad_idx) begin
            rdata = rdata ^ 32'h0000_0100;
            if (exp_err == 0) exp_first = ea;
            exp_err++;
          end
          n++; wait_c = 0;
          lat = (lat_fix >= 0) ? lat_fix : int'($urandom_range(0, 4));
        end
      end else begin
        chk("busy_in_gap", busy, 1'b1);
        gap_c++;
        hit = 1'($urandom_range(0, 1));
        rdata = $urandom;
      end
      @(negedge clk); start = 1'b0;
    end
    hit = 1'b0;
    chk("run_done", seen_done, 1'b1);
    chk("req_cnt", rcnt, num);
    chk("err_cnt", ecnt, exp_err);
    chk("stall_cnt", scnt, exp_stall);
    chk("first_err", ferr, exp_first);
    chk("end_flags", {busy, re, tmo}, 3'b000);
  endtask

  task automatic run_tout(input logic s);
    int cnt;
    sel = s; hit = 1'b0; cnt = 0;
    @(negedge clk); start = 1'b1; mode = 2'd0;
    @(negedge clk); start = 1'b0;
    for (int cyc = 0; cyc < 100 && re; cyc++) begin
      cnt++;
      @(negedge clk);
    end
    chk("tout_cycles", cnt, 16);
    chk("tout_flags", {tmo, busy, re, done}, 4'b1000);
    chk("tout_req_cnt", rcnt, 0);
    chk("tout_stall", scnt, 16);
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_outs", {re, busy, done, tmo, rcnt, ecnt}, 36'h0);
    chk("rst_addr", {addr, ferr, scnt}, 96'h0);
    @(negedge clk); rst = 1'b1;

    // Two good hits, then reset lands mid-request
    @(negedge clk); sel = 1'b0; start = 1'b1; mode = 2'd0;
    @(negedge clk); start = 1'b0;
    chk("first_addr", addr, 32'h1000);
    hit = 1'b1; rdata = 32'h1000 ^ KEY;
    @(negedge clk); rdata = 32'h1004 ^ KEY;
    @(negedge clk); hit = 1'b0;
    chk("pre_rst_cnt", {re, rcnt}, {1'b1, 16'd2});
    #2 rst = 1'b0;
    #1 chk("async_rst", {re, busy, rcnt, scnt}, 50'h0);
    @(negedge clk); rst = 1'b1;

    run(1'b0, 2'd0, 0, -1);     // back-to-back zero-wait sequential
    run(1'b1, 2'd1, 3, -1);     // strided, 3 wait cycles, gap 2
    run(1'b1, 2'd3, -1, 2);     // loop window, corrupt request 2
    run(1'b0, 2'd3, -1, 1);
    run_tout(1'b1);
    run_tout(1'b0);
    run(1'b1, 2'd2, -1, -1);    // LFSR pattern
    run(1'b0, 2'd2, 0, 0);
    for (int k = 0; k < 6; k++)
      run(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), -1, int'($urandom_range(0, 5)));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
